// File: rtl/lcd_sequencer_pkg.sv
// Shared definitions for the character-LCD sequencer: FSM states, HD44780
// command bytes, init nibbles and default timing values (50 MHz clock).
package lcd_sequencer_pkg;

  typedef enum logic [3:0] {
    POWER_WAIT,
    INIT_SETUP,
    INIT_PULSE,
    INIT_HOLD,
    INIT_WAIT,
    CFG_LOAD,
    IDLE,
    HI_SETUP,
    HI_PULSE,
    HI_HOLD,
    NIB_GAP,
    LO_SETUP,
    LO_PULSE,
    LO_HOLD,
    BYTE_WAIT
  } lcd_state_e;

  // HD44780 command bytes used by the configuration sequence
  localparam logic [7:0] CMD_FUNC_SET   = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;

  // Single-nibble wake-up writes issued before the bus is in 4-bit mode
  localparam logic [3:0] INIT_NIB_WAKE  = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT  = 4'h2;

  localparam int DEF_T_POWERON = 750000;
  localparam int DEF_T_INIT1   = 205000;
  localparam int DEF_T_INIT2   = 5000;
  localparam int DEF_T_CMD     = 2000;
  localparam int DEF_T_CLEAR   = 82000;
  localparam int DEF_T_NIB     = 50;
  localparam int DEF_T_SETUP   = 2;
  localparam int DEF_T_PULSE   = 12;
  localparam int DEF_CW        = 20;

  // Configuration byte sent at index idx after the wake-up nibbles
  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_ENTRY_MODE;
      2'd2:    return CMD_DISP_ON;
      default: return CMD_CLEAR;
    endcase
  endfunction

  // Clear and home need the long execution wait; everything else is short
  function automatic logic is_slow_cmd(input logic [7:0] b, input logic rs);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable down-counter. Loading N makes done rise in the N-th cycle after
// the load edge, so a state that loads N on entry and leaves on done lasts
// exactly N cycles. Loading 0 behaves like loading 1.
module lcd_wait_timer #(
  parameter int CW = 20
) (
  input  logic          clk,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          done
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload (stored as N-1) or count down and stick at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (value == '0) ? '0 : value - 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register; the parent forces a load while in reset
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 4-bit write-only sequencer: power-on init, configuration, then one
// byte per request split into two E-strobed nibbles with command wait times.
module lcd_sequencer
  import lcd_sequencer_pkg::*;
#(
  parameter int T_POWERON = DEF_T_POWERON,
  parameter int T_INIT1   = DEF_T_INIT1,
  parameter int T_INIT2   = DEF_T_INIT2,
  parameter int T_CMD     = DEF_T_CMD,
  parameter int T_CLEAR   = DEF_T_CLEAR,
  parameter int T_NIB     = DEF_T_NIB,
  parameter int T_SETUP   = DEF_T_SETUP,
  parameter int T_PULSE   = DEF_T_PULSE,
  parameter int CW        = DEF_CW
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iWrite,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  localparam logic [CW-1:0] T_POWERON_C = CW'(T_POWERON);
  localparam logic [CW-1:0] T_INIT1_C   = CW'(T_INIT1);
  localparam logic [CW-1:0] T_INIT2_C   = CW'(T_INIT2);
  localparam logic [CW-1:0] T_CMD_C     = CW'(T_CMD);
  localparam logic [CW-1:0] T_CLEAR_C   = CW'(T_CLEAR);
  localparam logic [CW-1:0] T_NIB_C     = CW'(T_NIB);
  localparam logic [CW-1:0] T_SETUP_C   = CW'(T_SETUP);
  localparam logic [CW-1:0] T_PULSE_C   = CW'(T_PULSE);
  localparam logic [CW-1:0] T_ONE_C     = CW'(1);

  lcd_state_e    state_q, state_d;
  logic [1:0]    init_step_q, init_step_d;
  logic [1:0]    cfg_idx_q, cfg_idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          rs_q, rs_d;
  logic          init_done_q, init_done_d;
  logic          ready_q, ready_d;
  logic          lcd_e_q, lcd_e_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic [3:0]    lcd_data_q, lcd_data_d;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;

  lcd_wait_timer #(.CW(CW)) u_timer (
    .clk   (Clock),
    .load  (tmr_load),
    .value (tmr_val),
    .done  (tmr_done)
  );

  // Next-state logic: every state advances on timer done; IDLE and CFG_LOAD
  // always see done because they are entered with a one-cycle load.
  always_comb begin
    state_d     = state_q;
    init_step_d = init_step_q;
    cfg_idx_d   = cfg_idx_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    if (tmr_done) begin
      case (state_q)
        POWER_WAIT: state_d = INIT_SETUP;
        INIT_SETUP: state_d = INIT_PULSE;
        INIT_PULSE: state_d = INIT_HOLD;
        INIT_HOLD:  state_d = INIT_WAIT;
        INIT_WAIT: begin
          if (init_step_q == 2'd3) begin
            state_d = CFG_LOAD;
          end else begin
            init_step_d = init_step_q + 2'd1;
            state_d     = INIT_SETUP;
          end
        end
        CFG_LOAD: begin
          byte_d  = cfg_byte(cfg_idx_q);
          rs_d    = 1'b0;
          state_d = HI_SETUP;
        end
        IDLE: begin
          if (ready_q && iWrite) begin
            byte_d  = iData;
            rs_d    = iRS;
            state_d = HI_SETUP;
          end
        end
        HI_SETUP: state_d = HI_PULSE;
        HI_PULSE: state_d = HI_HOLD;
        HI_HOLD:  state_d = NIB_GAP;
        NIB_GAP:  state_d = LO_SETUP;
        LO_SETUP: state_d = LO_PULSE;
        LO_PULSE: state_d = LO_HOLD;
        LO_HOLD:  state_d = BYTE_WAIT;
        BYTE_WAIT: begin
          if (init_done_q) begin
            state_d = IDLE;
          end else if (cfg_idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            cfg_idx_d = cfg_idx_q + 2'd1;
            state_d   = CFG_LOAD;
          end
        end
        default: state_d = POWER_WAIT;
      endcase
    end
  end

  // Timer reload: the duration of the state being entered, on every transition
  always_comb begin
    tmr_val = T_ONE_C;
    case (state_d)
      POWER_WAIT:                     tmr_val = T_POWERON_C;
      INIT_SETUP, HI_SETUP, LO_SETUP: tmr_val = T_SETUP_C;
      INIT_PULSE, HI_PULSE, LO_PULSE: tmr_val = T_PULSE_C;
      INIT_WAIT: begin
        case (init_step_q)
          2'd0:    tmr_val = T_INIT1_C;
          2'd1:    tmr_val = T_INIT2_C;
          default: tmr_val = T_CMD_C;
        endcase
      end
      NIB_GAP:   tmr_val = T_NIB_C;
      BYTE_WAIT: tmr_val = is_slow_cmd(byte_q, rs_q) ? T_CLEAR_C : T_CMD_C;
      default:   tmr_val = T_ONE_C;
    endcase
    if (!Reset) begin
      tmr_val = T_POWERON_C;
    end
    tmr_load = !Reset || (state_d != state_q);
  end

  // Output values for the next cycle: the nibble and RS change only on entry
  // to a SETUP state so they stay put through PULSE, HOLD and the nibble gap.
  always_comb begin
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    if (state_d != state_q) begin
      case (state_d)
        INIT_SETUP: begin
          lcd_data_d = (init_step_d == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
          lcd_rs_d   = 1'b0;
        end
        HI_SETUP: begin
          lcd_data_d = byte_d[7:4];
          lcd_rs_d   = rs_d;
        end
        LO_SETUP: lcd_data_d = byte_d[3:0];
        default:  lcd_data_d = lcd_data_q;
      endcase
    end
    lcd_e_d = (state_d == INIT_PULSE) || (state_d == HI_PULSE) ||
              (state_d == LO_PULSE);
    // Ready comes up one cycle after IDLE is entered and drops on accept
    ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= POWER_WAIT;
      init_step_q <= 2'd0;
      cfg_idx_q   <= 2'd0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      init_step_q <= init_step_d;
      cfg_idx_q   <= cfg_idx_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
    end
  end

  assign oReady    = ready_q;
  assign oInitDone = init_done_q;
  assign oLCD_E    = lcd_e_q;
  assign oLCD_RS   = lcd_rs_q;
  assign oLCD_RW   = 1'b0;
  assign oLCD_Data = lcd_data_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer with shortened timings.
module tb_lcd_sequencer;

  localparam int TP_ON = 20;
  localparam int TI1   = 10;
  localparam int TI2   = 6;
  localparam int TC    = 4;
  localparam int TCL   = 8;
  localparam int TN    = 3;
  localparam int TS    = 2;
  localparam int TPU   = 3;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iRS = 1'b0;
  logic       iWrite = 1'b0;
  logic       oReady, oInitDone, oLCD_E, oLCD_RS, oLCD_RW;
  logic [3:0] oLCD_Data;

  lcd_sequencer #(
    .T_POWERON(TP_ON), .T_INIT1(TI1), .T_INIT2(TI2), .T_CMD(TC),
    .T_CLEAR(TCL), .T_NIB(TN), .T_SETUP(TS), .T_PULSE(TPU), .CW(20)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iData(iData), .iRS(iRS), .iWrite(iWrite),
    .oReady(oReady), .oInitDone(oInitDone), .oLCD_E(oLCD_E),
    .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW), .oLCD_Data(oLCD_Data)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Observed E pulses on the LCD bus
  typedef struct {
    logic [3:0] nib;
    logic       rs;
    int         rise;
    int         fall;
  } pulse_t;

  pulse_t     obs[$];
  pulse_t     cur;
  bit         mon_en = 1'b0;
  bit         in_pulse = 1'b0;
  logic       e_prev = 1'b0;
  logic [4:0] bus_prev = 5'd0;

  always @(negedge Clock) begin
    if (mon_en) begin
      if (oLCD_E && !e_prev) begin
        cur.nib  = oLCD_Data;
        cur.rs   = oLCD_RS;
        cur.rise = cyc;
        cur.fall = -1;
        in_pulse = 1'b1;
        chk("setup_stable", int'(bus_prev), int'({oLCD_RS, oLCD_Data}));
      end else if (!oLCD_E && e_prev && in_pulse) begin
        in_pulse = 1'b0;
        if (Reset) begin
          cur.fall = cyc;
          chk("pulse_width", cyc - cur.rise, TPU);
          obs.push_back(cur);
        end
      end
    end
    e_prev   = oLCD_E;
    bus_prev = {oLCD_RS, oLCD_Data};
  end

  // Behavioural expectation: busy span of one byte from the documented rules
  function automatic int model_latency(input logic [7:0] b, input logic r);
    int w;
    w = (!r && (b == 8'h01 || b == 8'h02)) ? TCL : TC;
    return 2 * (TS + TPU + 1) + TN + w + 1;
  endfunction

  task automatic do_reset(output int t_r);
    @(negedge Clock);
    Reset = 1'b0;
    iWrite = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_e", oLCD_E, 0);
    chk("rst_rs", oLCD_RS, 0);
    chk("rst_data", oLCD_Data, 0);
    chk("rst_ready", oReady, 0);
    chk("rst_initdone", oInitDone, 0);
    chk("rst_rw", oLCD_RW, 0);
    obs.delete();
    mon_en = 1'b1;
    t_r = cyc;
    Reset = 1'b1;
  endtask

  task automatic check_init(input int t_r, input bit noise);
    logic [3:0] exp_nib [12];
    int n, t_done;
    exp_nib = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6,
                4'h0, 4'hC, 4'h0, 4'h1};
    n = 0;
    while (!oInitDone && n < 3000) begin
      if (noise) begin
        iWrite = 1'($urandom_range(0, 1));
        iData  = 8'($urandom);
        iRS    = 1'($urandom_range(0, 1));
      end
      @(negedge Clock);
      n++;
    end
    iWrite = 1'b0;
    t_done = cyc;
    chk("init_done_reached", oInitDone, 1);
    chk("init_ready_low", oReady, 0);
    chk("init_pulse_count", obs.size(), 12);
    if (obs.size() == 12) begin
      for (int i = 0; i < 12; i++)
        chk($sformatf("init_nib%0d", i), int'({obs[i].rs, obs[i].nib}),
            int'({1'b0, exp_nib[i]}));
      chk("first_e_rise", obs[0].rise - t_r, TP_ON + TS);
      chk("init_gap0", obs[1].rise - obs[0].fall, 1 + TI1 + TS);
      chk("init_gap1", obs[2].rise - obs[1].fall, 1 + TI2 + TS);
      chk("init_gap2", obs[3].rise - obs[2].fall, 1 + TC + TS);
      chk("initdone_time", t_done - obs[11].fall, 1 + TCL);
    end
    @(negedge Clock);
    chk("ready_after_init", oReady, 1);
    chk("no_extra_pulse_init", obs.size(), 12);
  endtask

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    while (!oReady && n < bound) begin
      @(negedge Clock);
      n++;
    end
  endtask

  task automatic do_write(input logic [7:0] b, input logic r, input int lat,
                          input bit noise);
    int t_a;
    wait_ready(500);
    chk("ready_before_write", oReady, 1);
    obs.delete();
    iData = b;
    iRS = r;
    iWrite = 1'b1;
    @(negedge Clock);
    t_a = cyc;
    chk("ready_drop_on_accept", oReady, 0);
    while (!oReady && (cyc - t_a) < 300) begin
      if (noise && (cyc - t_a) < lat - 2) begin
        iWrite = 1'($urandom_range(0, 1));
        iData  = 8'($urandom);
        iRS    = 1'($urandom_range(0, 1));
      end else begin
        iWrite = 1'b0;
      end
      @(negedge Clock);
    end
    iWrite = 1'b0;
    chk($sformatf("latency_%02h_rs%0d", b, r), cyc - t_a, lat);
    chk("byte_pulse_count", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("hi_nibble", int'({obs[0].rs, obs[0].nib}), int'({r, b[7:4]}));
      chk("lo_nibble", int'({obs[1].rs, obs[1].nib}), int'({r, b[3:0]}));
      chk("hi_rise_time", obs[0].rise - t_a, TS);
      chk("nib_gap", obs[1].rise - obs[0].fall, 1 + TN + TS);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         lat;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t_r, t_a, t_b;
    logic [7:0] b;
    logic r;

    vecs[0] = '{8'h48, 1'b1, 20};
    vecs[1] = '{8'h01, 1'b0, 24};
    vecs[2] = '{8'h02, 1'b0, 24};
    vecs[3] = '{8'h01, 1'b1, 20};
    vecs[4] = '{8'h02, 1'b1, 20};
    vecs[5] = '{8'h03, 1'b0, 20};
    vecs[6] = '{8'h80, 1'b0, 20};
    vecs[7] = '{8'hFF, 1'b1, 20};

    do_reset(t_r);
    check_init(t_r, 1'b1);

    for (int i = 0; i < 8; i++)
      do_write(vecs[i].data, vecs[i].rs, vecs[i].lat, (i % 2) == 1);

    for (int i = 0; i < 25; i++) begin
      b = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      if (i % 4 == 0) begin
        b = 8'($urandom_range(1, 2));
        r = 1'b0;
      end
      do_write(b, r, model_latency(b, r), 1'b1);
    end

    // iWrite held high across two bytes; iData changes right after accept
    wait_ready(500);
    obs.delete();
    iData = 8'h41;
    iRS = 1'b1;
    iWrite = 1'b1;
    @(negedge Clock);
    t_a = cyc;
    iData = 8'h42;
    while (!oReady && (cyc - t_a) < 300) @(negedge Clock);
    chk("b2b_first_latency", cyc - t_a, 20);
    @(negedge Clock);
    t_b = cyc;
    chk("b2b_reaccept", oReady, 0);
    chk("b2b_accept_cycle", t_b - t_a, 21);
    iWrite = 1'b0;
    while (!oReady && (cyc - t_b) < 300) @(negedge Clock);
    chk("b2b_second_latency", cyc - t_b, 20);
    chk("b2b_pulse_count", obs.size(), 4);
    if (obs.size() == 4) begin
      chk("b2b_n0", int'({obs[0].rs, obs[0].nib}), 5'h14);
      chk("b2b_n1", int'({obs[1].rs, obs[1].nib}), 5'h11);
      chk("b2b_n2", int'({obs[2].rs, obs[2].nib}), 5'h14);
      chk("b2b_n3", int'({obs[3].rs, obs[3].nib}), 5'h12);
    end

    // Reset while the low nibble is being strobed
    wait_ready(500);
    obs.delete();
    iData = 8'h55;
    iRS = 1'b1;
    iWrite = 1'b1;
    @(negedge Clock);
    iWrite = 1'b0;
    t_a = cyc;
    while (!(oLCD_E && obs.size() == 1) && (cyc - t_a) < 100) @(negedge Clock);
    chk("abort_in_lo_pulse", int'(oLCD_E && obs.size() == 1), 1);
    Reset = 1'b0;
    @(negedge Clock);
    chk("abort_e_low", oLCD_E, 0);
    chk("abort_initdone_low", oInitDone, 0);
    chk("abort_ready_low", oReady, 0);
    repeat (2) @(negedge Clock);
    obs.delete();
    t_r = cyc;
    Reset = 1'b1;
    check_init(t_r, 1'b0);
    do_write(8'h48, 1'b1, model_latency(8'h48, 1'b1), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
